// File: rtl/ring_arbiter.sv
// ring_arbiter: 4-requester round-robin arbiter with a rotating one-hot token.
// A requester keeps the resource for as long as it holds its req bit. When it
// lets go, the token moves to the next index and at least one idle cycle
// follows before any new grant.
//
// Optional feature: define RING_ARB_TIMEOUT_EN to revoke a grant after
// MAX_HOLD cycles. A revocation raises a one-cycle timeout pulse and rotates
// the token. Without the macro, grants are unlimited and timeout is tied to 0.
//
// Ports:
//   clk     - clock; all state changes on the rising edge
//   rst     - synchronous, active-low reset
//   req     - [3:0] per-requester request level
//   grant   - [3:0] one-hot (or zero) grant, registered
//   owner   - [1:0] index of current owner while busy, else 0, registered
//   busy    - high while any grant bit is set, registered
//   token   - [3:0] one-hot highest-priority requester, registered
//   timeout - one-cycle pulse when a grant is forcibly revoked, registered
module ring_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic [3:0] token,
  output logic       timeout
);

  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [N-1:0]      token_q, token_d;
  logic [IDX_W-1:0]  tok_idx_q, tok_idx_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  next_idx;

  // First requesting index at or above the token, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = tok_idx_q + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign next_idx = owner_q + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    token_d   = token_q;
    tok_idx_d = tok_idx_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          grant_d = N'(1) << pick;
          owner_d = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        if (!req[owner_q]) begin
          // Voluntary release; token moves past the releasing owner.
          state_d   = IDLE;
          grant_d   = '0;
          owner_d   = '0;
          busy_d    = 1'b0;
          tok_idx_d = next_idx;
          token_d   = N'(1) << next_idx;
`ifdef RING_ARB_TIMEOUT_EN
        end else if (cnt_q == HOLD_LIMIT) begin
          // Owner still requesting at the limit: revoke and rotate.
          state_d   = IDLE;
          grant_d   = '0;
          owner_d   = '0;
          busy_d    = 1'b0;
          tok_idx_d = next_idx;
          token_d   = N'(1) << next_idx;
          timeout_d = 1'b1;
`endif
        end else if (cnt_q != HOLD_LIMIT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      token_q   <= N'(1);
      tok_idx_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      token_q   <= token_d;
      tok_idx_q <= tok_idx_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign token   = token_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter: directed scenarios plus randomized
// traffic checked against an index-based behavioural model of the arbiter.
module tb_ring_arbiter;

  localparam int unsigned MAX_HOLD = 8;
`ifdef RING_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] token;
  logic       timeout;

  int vectors;
  int errors;

  ring_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .token  (token),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: current owner index (-1 when idle), priority index, hold cycles.
  int m_own;
  int m_tok;
  int m_cnt;
  bit m_to;

  function automatic void model_step(input logic r, input logic [3:0] q);
    if (!r) begin
      m_own = -1; m_tok = 0; m_cnt = 0; m_to = 1'b0;
    end else if (m_own < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_own < 0 && q[(m_tok + k) % 4]) begin
          m_own = (m_tok + k) % 4;
          m_cnt = 0;
        end
      end
    end else if (!q[m_own]) begin
      m_tok = (m_own + 1) % 4; m_own = -1; m_to = 1'b0;
    end else if (TO_EN && m_cnt == int'(MAX_HOLD) - 1) begin
      m_tok = (m_own + 1) % 4; m_own = -1; m_to = 1'b1;
    end else begin
      m_to = 1'b0;
      if (m_cnt < int'(MAX_HOLD) - 1) m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] g;
    logic [1:0] o;
    g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    o = (m_own >= 0) ? 2'(m_own) : 2'd0;
    return {g, o, (m_own >= 0), 4'(1 << m_tok), m_to};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {grant, owner, busy, token, timeout};
  endfunction

  // Apply inputs, take one rising edge, advance the model, settle for sampling.
  task automatic tick(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b1010);
    vectors++;
    if (obs_vec() !== 12'b0000_00_0_0001_0) begin
      errors++;
      $display("FAIL reset: got g=%b o=%0d b=%b t=%b to=%b want all 0, token 0001",
               grant, owner, busy, token, timeout);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  // All four request continuously; each owner drops req for one cycle in turn.
  task automatic test_rotation();
    logic [3:0] want [5];
    logic [3:0] q;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (grant !== want[i] || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rotation[%0d]: got grant=%b want %b (vec %b want %b)",
                 i, grant, want[i], obs_vec(), exp_vec());
      end
      q = 4'b1111 & ~want[i];
      tick(1'b1, q);
      vectors++;
      if (grant !== 4'b0000 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_gap[%0d]: got grant=%b want 0000", i, grant);
      end
      tick(1'b1, 4'b1111);
    end
  endtask

  // Token at bit 2, requests only on 0 and 1: scan wraps and picks 0.
  task automatic test_wrap();
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b0000);
    vectors++;
    if (token !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_setup: got token=%b want 0100", token);
    end
    tick(1'b1, 4'b0011);
    vectors++;
    if (grant !== 4'b0001 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL wrap_grant: got grant=%b want 0001", grant);
    end
    tick(1'b1, 4'b0010);
    vectors++;
    if (token !== 4'b0010 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_release: got token=%b grant=%b want 0010/0000", token, grant);
    end
  endtask

  // Requester 3 pulses while 1 holds: 3 must never be granted.
  task automatic test_ignore_pulse();
    bit saw3;
    saw3 = 1'b0;
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b1010);
    saw3 |= grant[3];
    tick(1'b1, 4'b1010);
    saw3 |= grant[3];
    tick(1'b1, 4'b0010);
    saw3 |= grant[3];
    vectors++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL pulse_hold: got grant=%b want 0010", grant);
    end
    tick(1'b1, 4'b0000);
    saw3 |= grant[3];
    tick(1'b1, 4'b0000);
    saw3 |= grant[3];
    vectors++;
    if (saw3 || grant !== 4'b0000 || token !== 4'b0100) begin
      errors++;
      $display("FAIL pulse_ignore: got saw3=%b grant=%b token=%b want 0/0000/0100",
               saw3, grant, token);
    end
  endtask

  // Reset while requester 3 owns the resource with token at 3.
  task automatic test_reset_in_hold();
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b1000);
    vectors++;
    if (grant !== 4'b1000 || token !== 4'b1000) begin
      errors++;
      $display("FAIL rsthold_setup: got grant=%b token=%b want 1000/1000", grant, token);
    end
    tick(1'b0, 4'b1000);
    vectors++;
    if (grant !== 4'b0000 || busy !== 1'b0 || token !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rsthold: got g=%b b=%b t=%b to=%b want 0000/0/0001/0",
               grant, busy, token, timeout);
    end
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b1111);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_held: got busy=%b want 0", busy);
    end
    tick(1'b1, 4'b1111);
    vectors++;
    if (grant !== 4'b0001 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rst_resume: got grant=%b want 0001", grant);
    end
  endtask

  // Held request is revoked after MAX_HOLD cycles; a fall at the limit is a release.
  task automatic test_timeout();
    int len;
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0100);
    len = 0;
    while (grant[2] === 1'b1 && len < 300) begin
      len++;
      tick(1'b1, 4'b0100);
    end
    vectors++;
    if (len !== int'(MAX_HOLD) || timeout !== 1'b1 || token !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_len: got len=%0d to=%b token=%b want %0d/1/1000",
               len, timeout, token, MAX_HOLD);
    end
    tick(1'b1, 4'b0100);
    vectors++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b want 0", timeout);
    end
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0100);
    for (int i = 0; i < int'(MAX_HOLD) - 1; i++) tick(1'b1, 4'b0100);
    vectors++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL limit_setup: got grant=%b want 0100", grant);
    end
    tick(1'b1, 4'b0000);
    vectors++;
    if (timeout !== 1'b0 || token !== 4'b1000 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL limit_release: got to=%b token=%b grant=%b want 0/1000/0000",
               timeout, token, grant);
    end
  endtask

  // Long held request without the timeout feature: grant never drops.
  task automatic test_unlimited();
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b0100);
    for (int i = 0; i < 3 * int'(MAX_HOLD); i++) tick(1'b1, 4'b0100);
    vectors++;
    if (grant !== 4'b0100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL unlimited: got grant=%b to=%b want 0100/0", grant, timeout);
    end
  endtask

  // Random sticky request traffic with occasional resets.
  task automatic test_random();
    logic [3:0] q;
    logic       r;
    q = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) q[b] = ~q[b];
      end
      r = ($urandom_range(0, 99) != 0);
      tick(r, q);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: req=%b rst=%b got {g,o,b,t,to}=%b want %b",
                 c, q, r, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_own = -1; m_tok = 0; m_cnt = 0; m_to = 1'b0;
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_wrap();
    test_ignore_pulse();
    test_reset_in_hold();
    if (TO_EN) test_timeout();
    else       test_unlimited();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum grant length in cycles when timeout is compiled in; legal range 2..255.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester request; requester i holds req[i]=1 for as long as it wants the shared resource.
REQ-005 grant  output  4  one-hot or zero; grant[i]=1 means requester i owns the resource this cycle.
REQ-006 owner  output  2  binary index of the current owner; valid only while busy=1, 0 otherwise.
REQ-007 busy  output  1  1 while any grant bit is set.
REQ-008 token  output  4  one-hot rotating priority pointer; the bit set marks the highest-priority requester.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 All outputs SHALL be registered; no combinational path from req to any output.
REQ-011 FSM SHALL have exactly two states: IDLE (grant=0) and HOLD (one grant bit set).
REQ-012 IDLE, req sampled nonzero at an edge: next cycle SHALL enter HOLD and grant the first set req bit found scanning from the token position upward, mod 4.
REQ-013 IDLE, req=0: SHALL remain in IDLE; grant, owner, busy and token unchanged.
REQ-014 HOLD, req[owner]=1: grant SHALL stay unchanged; other req bits SHALL be ignored.
REQ-015 HOLD, req[owner] sampled 0: next cycle grant=0, state IDLE, token SHALL become one-hot of (owner+1) mod 4.
REQ-016 A release SHALL always produce at least one cycle with grant=0 before the next grant; minimum grant-to-grant spacing is one idle cycle.
REQ-017 Requester 3 releasing SHALL wrap token to 4'b0001.
REQ-018 A req bit that is set and then cleared while the block is in HOLD SHALL never receive a grant.
REQ-019 token SHALL stay one-hot at all times; it changes only on release or timeout.
REQ-020 The internal hold counter SHALL clear on entry to HOLD and increment once per HOLD cycle, saturating at MAX_HOLD-1.
REQ-021 timeout SHALL be 0 in every cycle not covered by REQ-027.

Reset
REQ-022 rst=0 at an edge SHALL force state IDLE, grant=4'b0000, owner=0, busy=0, token=4'b0001, timeout=0 and hold counter 0, on the next cycle.
REQ-023 Reset during HOLD SHALL drop the grant on the next cycle without a timeout pulse or a token rotation past the owner.
REQ-024 With rst=0 held, req SHALL be ignored; arbitration SHALL resume on the first edge with rst=1.

Configuration
REQ-025 Macro RING_ARB_TIMEOUT_EN SHALL select forced grant revocation.
REQ-026 Without RING_ARB_TIMEOUT_EN: grants are unlimited in length; timeout is tied 0; MAX_HOLD has no effect.
REQ-027 With RING_ARB_TIMEOUT_EN: when the hold counter equals MAX_HOLD-1 and req[owner]=1, the next cycle SHALL give grant=0, state IDLE, timeout=1 for one cycle, and token=one-hot of (owner+1) mod 4.
REQ-028 With RING_ARB_TIMEOUT_EN, if req[owner] falls in the same cycle the limit is reached, this SHALL be a normal release (timeout stays 0).
REQ-029 With RING_ARB_TIMEOUT_EN, an owner whose grant was revoked but still holds req SHALL be re-granted only through normal rotation.

Verification
REQ-030 Reset, then req=4'b1111 held -> grants cycle 0001, 0010, 0100, 1000, 0001 as each owner drops req for one cycle; at least one grant=0 cycle between grants.
REQ-031 token=4'b0100, req=4'b0011 -> grant=4'b0001 (wrap from bit 2); on release token=4'b0010.
REQ-032 req=4'b0010 granted, req[3] pulsed during HOLD -> grant[3] never set; grant 0010 is held until req[1] falls.
REQ-033 RING_ARB_TIMEOUT_EN, MAX_HOLD=8, req[2] held high -> grant[2]=1 for exactly 8 cycles, then timeout=1 for one cycle; token=4'b1000.
REQ-034 RING_ARB_TIMEOUT_EN, req[2] falls in the same cycle the limit is reached -> timeout stays 0 and token=4'b1000.
REQ-035 rst=0 asserted in HOLD with token=4'b1000 -> next cycle grant=0, busy=0, token=4'b0001, timeout=0.
